button_counter3: RTL and testbench

- Upstream stage of the 3-bit seven-segment decoder.
- Turns two raw, bouncing pushbuttons (increment, decrement) into a clean 3-bit value 0..7 that drives the decoder's number input directly.
- Each button passes through a synchronizer, a debounce filter and a press-edge detector; the resulting events step a modulo-8 counter.

---
 rtl/button_counter3.sv | 90 +++++++++
 tb/tb_button_counter3.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_counter3.sv
// Two bouncing pushbuttons (increment / decrement) step a 3-bit modulo-8 counter.
// Each button path: 2-flop synchronizer, debounce filter, registered press-edge event.
module button_counter3 #(
   parameter int         DEBOUNCE_CYCLES = 500000,
   parameter bit         ACTIVE_LOW      = 1'b1,
   parameter logic [2:0] INIT_VALUE      = 3'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_inc,
   input  logic       btn_dec,
   output logic [2:0] number,
   output logic       changed,
   output logic       inc_pressed,
   output logic       dec_pressed
);

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic          REL     = ACTIVE_LOW;

   // Index 0 is the increment button, index 1 the decrement button.
   logic [1:0]    raw;
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    pressed_sync;
   logic [1:0]    stable;
   logic [1:0]    evt;
   logic [CW-1:0] cnt [2];

   assign raw          = {btn_dec, btn_inc};
   assign pressed_sync = ACTIVE_LOW ? ~sync2 : sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= {2{REL}};
         sync2 <= {2{REL}};
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable <= 2'b00;
         evt    <= 2'b00;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            evt[i] <= 1'b0;
            if (pressed_sync[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               stable[i] <= pressed_sync[i];
               cnt[i]    <= '0;
               evt[i]    <= pressed_sync[i];
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // Simultaneous inc and dec events cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         number  <= INIT_VALUE;
         changed <= 1'b0;
      end else begin
         case (evt)
            2'b01: begin
               number  <= number + 3'd1;
               changed <= 1'b1;
            end
            2'b10: begin
               number  <= number - 3'd1;
               changed <= 1'b1;
            end
            default: changed <= 1'b0;
         endcase
      end
   end

   assign inc_pressed = stable[0];
   assign dec_pressed = stable[1];

endmodule

// File: tb/tb_button_counter3.sv
// Directed bench for button_counter3 with DEBOUNCE_CYCLES=4, active-low buttons, reset value 0.
// Outputs are sampled 1 time unit after each rising edge; "edge n" counts from the first edge after a stimulus change.
module tb_button_counter3;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_inc;
   logic       btn_dec;
   logic [2:0] number;
   logic       changed;
   logic       inc_pressed;
   logic       dec_pressed;

   int checks   = 0;
   int failures = 0;

   button_counter3 #(
      .DEBOUNCE_CYCLES(4),
      .ACTIVE_LOW     (1'b1),
      .INIT_VALUE     (3'd0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_inc    (btn_inc),
      .btn_dec    (btn_dec),
      .number     (number),
      .changed    (changed),
      .inc_pressed(inc_pressed),
      .dec_pressed(dec_pressed)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic release_all();
      btn_inc = 1'b1;
      btn_dec = 1'b1;
      tick(10);
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      btn_inc = 1'b1;
      btn_dec = 1'b1;
      tick(2);
      checks++;
      if (number !== 3'd0 || changed !== 1'b0 || inc_pressed !== 1'b0 || dec_pressed !== 1'b0) begin
         failures++;
         $display("FAIL reset_active: number=%0d changed=%b inc=%b dec=%b, required 0 0 0 0",
                  number, changed, inc_pressed, dec_pressed);
      end
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick(1);
         checks++;
         if (number !== 3'd0 || changed !== 1'b0 || inc_pressed !== 1'b0 || dec_pressed !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle cycle %0d: number=%0d changed=%b inc=%b dec=%b, required 0 0 0 0",
                     c, number, changed, inc_pressed, dec_pressed);
         end
      end
   endtask

   task automatic test_hold();
      btn_inc = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         tick(1);
         checks++;
         if (inc_pressed !== 1'b0 || number !== 3'd0 || changed !== 1'b0) begin
            failures++;
            $display("FAIL hold_early edge %0d: inc=%b number=%0d changed=%b, required 0 0 0",
                     e, inc_pressed, number, changed);
         end
      end
      tick(1);
      checks++;
      if (inc_pressed !== 1'b1 || number !== 3'd0) begin
         failures++;
         $display("FAIL hold_edge6: inc=%b number=%0d, required 1 0", inc_pressed, number);
      end
      tick(1);
      checks++;
      if (number !== 3'd1 || changed !== 1'b1) begin
         failures++;
         $display("FAIL hold_edge7: number=%0d changed=%b, required 1 1", number, changed);
      end
      tick(1);
      checks++;
      if (number !== 3'd1 || changed !== 1'b0) begin
         failures++;
         $display("FAIL hold_edge8: number=%0d changed=%b, required 1 0", number, changed);
      end
      for (int c = 0; c < 42; c++) begin
         tick(1);
         checks++;
         if (number !== 3'd1 || changed !== 1'b0 || inc_pressed !== 1'b1) begin
            failures++;
            $display("FAIL hold_steady cycle %0d: number=%0d changed=%b inc=%b, required 1 0 1",
                     c, number, changed, inc_pressed);
         end
      end
      btn_inc = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick(1);
         checks++;
         if (number !== 3'd1 || changed !== 1'b0) begin
            failures++;
            $display("FAIL hold_release cycle %0d: number=%0d changed=%b, required 1 0", c, number, changed);
         end
      end
      checks++;
      if (inc_pressed !== 1'b0) begin
         failures++;
         $display("FAIL hold_released_flag: inc=%b, required 0", inc_pressed);
      end
   endtask

   task automatic test_bounce();
      for (int b = 0; b < 5; b++) begin
         for (int c = 0; c < 6; c++) begin
            btn_inc = (c < 3) ? 1'b0 : 1'b1;
            tick(1);
            checks++;
            if (number !== 3'd1 || changed !== 1'b0 || inc_pressed !== 1'b0) begin
               failures++;
               $display("FAIL bounce burst %0d cycle %0d: number=%0d changed=%b inc=%b, required 1 0 0",
                        b, c, number, changed, inc_pressed);
            end
         end
      end
      btn_inc = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick(1);
         checks++;
         if (number !== 3'd1 || changed !== 1'b0) begin
            failures++;
            $display("FAIL bounce_settle edge %0d: number=%0d changed=%b, required 1 0", e, number, changed);
         end
      end
      tick(1);
      checks++;
      if (number !== 3'd2 || changed !== 1'b1) begin
         failures++;
         $display("FAIL bounce_edge7: number=%0d changed=%b, required 2 1", number, changed);
      end
      release_all();
      checks++;
      if (number !== 3'd2) begin
         failures++;
         $display("FAIL bounce_after_release: number=%0d, required 2", number);
      end
   endtask

   task automatic test_wrap();
      logic [2:0] exp;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
      checks++;
      if (number !== 3'd0) begin
         failures++;
         $display("FAIL wrap_start: number=%0d, required 0", number);
      end
      for (int k = 1; k <= 8; k++) begin
         exp = (k == 8) ? 3'd0 : 3'(k);
         btn_inc = 1'b0;
         tick(7);
         checks++;
         if (number !== exp || changed !== 1'b1) begin
            failures++;
            $display("FAIL wrap_inc press %0d: number=%0d changed=%b, required %0d 1", k, number, changed, exp);
         end
         tick(1);
         checks++;
         if (changed !== 1'b0) begin
            failures++;
            $display("FAIL wrap_pulse press %0d: changed=%b, required 0", k, changed);
         end
         release_all();
      end
      btn_dec = 1'b0;
      tick(7);
      checks++;
      if (number !== 3'd7 || changed !== 1'b1) begin
         failures++;
         $display("FAIL wrap_dec: number=%0d changed=%b, required 7 1", number, changed);
      end
      release_all();
   endtask

   task automatic test_both();
      btn_inc = 1'b0;
      btn_dec = 1'b0;
      tick(5);
      checks++;
      if (inc_pressed !== 1'b0 || dec_pressed !== 1'b0) begin
         failures++;
         $display("FAIL both_edge5: inc=%b dec=%b, required 0 0", inc_pressed, dec_pressed);
      end
      tick(1);
      checks++;
      if (inc_pressed !== 1'b1 || dec_pressed !== 1'b1) begin
         failures++;
         $display("FAIL both_edge6: inc=%b dec=%b, required 1 1", inc_pressed, dec_pressed);
      end
      for (int c = 0; c < 10; c++) begin
         tick(1);
         checks++;
         if (number !== 3'd7 || changed !== 1'b0) begin
            failures++;
            $display("FAIL both_hold cycle %0d: number=%0d changed=%b, required 7 0", c, number, changed);
         end
      end
      release_all();
      btn_dec = 1'b0;
      tick(7);
      checks++;
      if (number !== 3'd6 || changed !== 1'b1) begin
         failures++;
         $display("FAIL both_then_dec: number=%0d changed=%b, required 6 1", number, changed);
      end
      release_all();
   endtask

   task automatic test_reset_mid();
      btn_dec = 1'b0;
      tick(7);
      checks++;
      if (number !== 3'd5) begin
         failures++;
         $display("FAIL mid_setup: number=%0d, required 5", number);
      end
      release_all();
      btn_inc = 1'b0;
      tick(4);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (number !== 3'd0 || inc_pressed !== 1'b0 || dec_pressed !== 1'b0 || changed !== 1'b0) begin
         failures++;
         $display("FAIL mid_async_reset: number=%0d inc=%b dec=%b changed=%b, required 0 0 0 0",
                  number, inc_pressed, dec_pressed, changed);
      end
      #1;
      rst = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick(1);
         checks++;
         if (number !== 3'd0 || changed !== 1'b0) begin
            failures++;
            $display("FAIL mid_restart edge %0d: number=%0d changed=%b, required 0 0", e, number, changed);
         end
      end
      tick(1);
      checks++;
      if (number !== 3'd1 || changed !== 1'b1) begin
         failures++;
         $display("FAIL mid_edge7: number=%0d changed=%b, required 1 1", number, changed);
      end
      release_all();
   endtask

   initial begin
      test_reset();
      test_hold();
      test_bounce();
      test_wrap();
      test_both();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
